// File: rtl/dmem_arb_pkg.sv
// Shared types for the MEM-stage data-memory arbiter: FSM states and lane indices.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L0   = 2'd1,
        L1   = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Increment-enable counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises the two MEM-stage lanes onto one req/ack data-memory port, lane 0 first,
// holding both lanes stalled until the pair completes.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rd0,
    input  logic            rd1,
    input  logic            wr0,
    input  logic            wr1,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic            stall_mem,
    output logic [DW-1:0]   rdata0,
    output logic [DW-1:0]   rdata1,
    output logic [CNTW-1:0] conflict_cnt
);

    arb_state_e    state_q, state_d;
    logic          v0, v1;
    logic          busy;
    logic          lane;
    logic          cap0, cap1;
    logic          conflict_inc;
    logic [DW-1:0] rdata0_q, rdata1_q;

    assign v0 = rd0 | wr0;
    assign v1 = rd1 | wr1;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (v0) begin
                    state_d = L0;
                end else if (v1) begin
                    state_d = L1;
                end
            end
            L0: begin
                if (mem_ack) begin
                    state_d = v1 ? L1 : DONE;
                end
            end
            L1: begin
                if (mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: memory port muxed from the lane currently served
    always_comb begin
        busy      = (state_q == L0) || (state_q == L1);
        lane      = (state_q == L1) ? LANE1 : LANE0;
        mem_req   = busy;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (busy) begin
            unique case (lane)
                LANE0: begin
                    mem_we    = wr0;
                    mem_addr  = addr0;
                    mem_wdata = wdata0;
                end
                LANE1: begin
                    mem_we    = wr1;
                    mem_addr  = addr1;
                    mem_wdata = wdata1;
                end
                default: begin
                    mem_we    = 1'b0;
                    mem_addr  = '0;
                    mem_wdata = '0;
                end
            endcase
        end
        // Drops in DONE so the pipeline advances on the edge that leaves it
        stall_mem = (v0 | v1) && (state_q != DONE);
    end

    // A lane with both rd and wr set is a store: no read-data capture
    assign cap0 = (state_q == L0) && mem_ack && rd0 && !wr0;
    assign cap1 = (state_q == L1) && mem_ack && rd1 && !wr1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (cap0) begin
                rdata0_q <= mem_rdata;
            end
            if (cap1) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

    assign conflict_inc = (state_q == IDLE) && v0 && v1;

    sat_counter #(
        .W(CNTW)
    ) u_conflict_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (conflict_inc),
        .count(conflict_cnt)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: a memory model checks each bus transaction
// against queued expectations, a pair monitor checks stall length, read data and conflict count.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    // Narrow counter so saturation is reachable within a short run
    localparam int unsigned CNTW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            rd0, rd1, wr0, wr1;
    logic [AW-1:0]   addr0, addr1;
    logic [DW-1:0]   wdata0, wdata1;
    logic            mem_req, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;
    logic            stall_mem;
    logic [DW-1:0]   rdata0, rdata1;
    logic [CNTW-1:0] conflict_cnt;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .AW  (AW),
        .DW  (DW),
        .CNTW(CNTW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd0         (rd0),
        .rd1         (rd1),
        .wr0         (wr0),
        .wr1         (wr1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stall_mem   (stall_mem),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .conflict_cnt(conflict_cnt)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
    } txn_t;

    typedef struct {
        int          stall;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [3:0]  cnt;
    } pair_t;

    typedef struct {
        logic        rd0, wr0, rd1, wr1;
        logic [31:0] a0, a1, d0, d1;
        int          w0, w1;
        int          stall;
        logic [31:0] r0, r1;
        logic [3:0]  cnt;
    } vec_t;

    txn_t        txn_q[$];
    pair_t       pair_q[$];
    logic [31:0] mem [logic [31:0]];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r0i, input logic w0i, input logic r1i,
                                input logic w1i, input logic [31:0] a0i, input logic [31:0] d0i,
                                input logic [31:0] a1i, input logic [31:0] d1i,
                                input int w0c, input int w1c, input int st,
                                input logic [31:0] er0, input logic [31:0] er1,
                                input logic [3:0] ecnt);
        vec_t v;
        v.rd0 = r0i; v.wr0 = w0i; v.rd1 = r1i; v.wr1 = w1i;
        v.a0 = a0i;  v.d0 = d0i;  v.a1 = a1i;  v.d1 = d1i;
        v.w0 = w0c;  v.w1 = w1c;  v.stall = st;
        v.r0 = er0;  v.r1 = er1;  v.cnt = ecnt;
        return v;
    endfunction

    // Memory model and bus monitor: acks after the queued wait count, checks hold stability
    int          wcnt = 0;
    logic        in_txn = 1'b0;
    logic        l_we;
    logic [31:0] l_addr, l_wdata;

    always @(negedge clk) begin
        txn_t t;
        if (!mem_req) begin
            mem_ack = 1'b0;
            wcnt    = 0;
            in_txn  = 1'b0;
        end else begin
            if (!in_txn) begin
                l_we    = mem_we;
                l_addr  = mem_addr;
                l_wdata = mem_wdata;
                in_txn  = 1'b1;
            end else begin
                chk("hold_we", mem_we, l_we);
                chk("hold_addr", mem_addr, l_addr);
                chk("hold_wdata", mem_wdata, l_wdata);
            end
            if (txn_q.size() == 0) begin
                chk("unexpected_req", mem_req, 1'b0);
                mem_ack = 1'b1;
                in_txn  = 1'b0;
            end else if (wcnt >= txn_q[0].waits) begin
                t = txn_q.pop_front();
                chk("bus_we", mem_we, t.we);
                chk("bus_addr", mem_addr, t.addr);
                chk("bus_wdata", mem_wdata, t.wdata);
                mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                end
                mem_ack = 1'b1;
                wcnt    = 0;
                in_txn  = 1'b0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Pair monitor: when a stall window closes, compare its length and results
    int scnt = 0;

    always @(negedge clk) begin
        pair_t p;
        if (!reset) begin
            scnt = 0;
        end else if (stall_mem) begin
            scnt++;
        end else if (scnt != 0) begin
            if (pair_q.size() == 0) begin
                chk("unexpected_pair", 1'b1, 1'b0);
            end else begin
                p = pair_q.pop_front();
                chk("stall_cycles", scnt, p.stall);
                chk("rdata0", rdata0, p.r0);
                chk("rdata1", rdata1, p.r1);
                chk("conflict_cnt", conflict_cnt, p.cnt);
            end
            scnt = 0;
        end
    end

    task automatic drive(input vec_t v);
        txn_t  t;
        pair_t p;
        @(posedge clk);
        #1;
        rd0 = v.rd0; wr0 = v.wr0; rd1 = v.rd1; wr1 = v.wr1;
        addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
        if (v.rd0 | v.wr0) begin
            t.we = v.wr0; t.addr = v.a0; t.wdata = v.d0; t.waits = v.w0;
            txn_q.push_back(t);
        end
        if (v.rd1 | v.wr1) begin
            t.we = v.wr1; t.addr = v.a1; t.wdata = v.d1; t.waits = v.w1;
            txn_q.push_back(t);
        end
        if (v.rd0 | v.wr0 | v.rd1 | v.wr1) begin
            p.stall = v.stall; p.r0 = v.r0; p.r1 = v.r1; p.cnt = v.cnt;
            pair_q.push_back(p);
        end
    endtask

    task automatic run_pair(input vec_t v);
        bit done = 1'b0;
        drive(v);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stall_mem) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            chk("pair_timeout", 1'b0, 1'b1);
        end
    endtask

    task automatic clear_inputs();
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, mem_req, 1'b0);
        chk({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_addr"}, mem_addr, '0);
        chk({tag, "_wdata"}, mem_wdata, '0);
        chk({tag, "_rdata0"}, rdata0, '0);
        chk({tag, "_rdata1"}, rdata1, '0);
        chk({tag, "_cnt"}, conflict_cnt, '0);
        chk({tag, "_state"}, dut.state_q, IDLE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[6];

    initial begin
        vec_t v;
        bit   found;
        reset     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        clear_inputs();
        mem[32'h10] = 32'hDEAD_BEEF;

        #1;
        chk_reset_outputs("por");
        chk("por_stall", stall_mem, 1'b0);
        #21;
        reset = 1'b1;

        //            rd0 wr0 rd1 wr1 a0      d0            a1      d1            w0 w1 st r0            r1            cnt
        vecs[0] = mk(1, 0, 0, 0, 32'h10, 32'h0,        32'h0,  32'h0,        0, 0, 2, 32'hDEADBEEF, 32'h0,        4'd0);
        vecs[1] = mk(0, 1, 1, 0, 32'h20, 32'h55,       32'h20, 32'h0,        0, 0, 3, 32'hDEADBEEF, 32'h55,       4'd1);
        vecs[2] = mk(0, 0, 0, 1, 32'h0,  32'h0,        32'h30, 32'hA5A5A5A5, 0, 2, 4, 32'hDEADBEEF, 32'h55,       4'd1);
        vecs[3] = mk(1, 1, 1, 0, 32'h40, 32'h1234,     32'h40, 32'h0,        0, 0, 3, 32'hDEADBEEF, 32'h1234,     4'd2);
        vecs[4] = mk(0, 0, 1, 0, 32'h0,  32'h0,        32'h10, 32'h0,        0, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF, 4'd2);
        vecs[5] = mk(1, 0, 1, 0, 32'h30, 32'h0,        32'h20, 32'h0,        1, 1, 5, 32'hA5A5A5A5, 32'h55,       4'd3);

        foreach (vecs[i]) begin
            run_pair(vecs[i]);
        end

        // Pairs with no memory access: no stall, no request
        for (int i = 0; i < 10; i++) begin
            run_pair(mk(0, 0, 0, 0, 32'h10 + i, 32'h0, 32'h20 + i, 32'h0, 0, 0, 0,
                        32'h0, 32'h0, 4'd0));
            chk("noacc_stall", stall_mem, 1'b0);
            chk("noacc_req", mem_req, 1'b0);
        end

        // Reset while lane 1 waits for its ack
        v = mk(0, 1, 1, 0, 32'h50, 32'h77, 32'h50, 32'h0, 0, 20, 0, 32'h0, 32'h0, 4'd0);
        drive(v);
        void'(pair_q.pop_back());
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req && !mem_we && (mem_addr == 32'h50)) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached_l1", found, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        txn_q.delete();
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Conflicting pairs until the counter saturates and holds
        for (int i = 1; i <= 17; i++) begin
            run_pair(mk(1, 0, 1, 0, 32'h10, 32'h0, 32'h10, 32'h0, 0, 0, 3,
                        32'hDEADBEEF, 32'hDEADBEEF, (i < 15) ? 4'(i) : 4'hF));
        end

        @(posedge clk);
        #1;
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("txn_q_drained", txn_q.size(), 0);
        chk("pair_q_drained", pair_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer that shares the single data-memory port between the two MEM-stage lanes of the dual-issue pipeline. Lane 0 is the older instruction of the issued pair; it is always served first. The block serialises the pair's loads and stores onto a req/ack memory port. It holds both MEM stages stalled until the whole pair is done, and returns per-lane read data to the write-back path.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- CNTW, 16, width of the conflict counter

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- rd0 / rd1  in  1  lane 0/1 MEM-stage load (memtoreg)
- wr0 / wr1  in  1  lane 0/1 MEM-stage store (memwrite)
- addr0 / addr1  in  AW  lane 0/1 ALU result used as the address
- wdata0 / wdata1  in  DW  lane 0/1 store data
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid when mem_ack = 1
- mem_ack  in  1  transaction completes at this rising edge
- stall_mem  out  1  freeze the MEM/WB and earlier stages of both lanes
- rdata0 / rdata1  out  DW  captured load data for lane 0/1
- conflict_cnt  out  CNTW  saturating count of pairs in which both lanes accessed memory

## Operation
- Lane request: v_i = rd_i | wr_i. If a lane has both rd_i and wr_i set, the write wins and the transaction is a write with no rdata capture.
- States:
  - IDLE: if v0, go to L0. Else if v1, go to L1. Else stay in IDLE.
  - L0: drive lane 0 fields. On mem_ack, go to L1 if v1, otherwise go to DONE.
  - L1: drive lane 1 fields. On mem_ack, go to DONE.
  - DONE: always go to IDLE.
- mem_req = 1 in L0 and in L1. mem_we, mem_addr and mem_wdata are muxed combinationally from the lane being served. These outputs are 0 in IDLE and DONE.
- stall_mem = (v0 | v1) & (state != DONE). It is combinational. The pipeline advances on the edge that ends DONE.
- Lane inputs are stable while stall_mem = 1, so the block captures no request fields.
- rdata_i is loaded with mem_rdata on the acknowledged read of lane i. Otherwise it holds its value.
- conflict_cnt increments by 1 on the IDLE→L0 transition when v1 = 1. It saturates at 2^CNTW−1.
- Program order: lane 0 reaches memory strictly before lane 1. When both lanes use the same address, a lane 0 store followed by a lane 1 load returns the stored data.
- A pair with no memory access passes through IDLE with stall_mem = 0 and zero penalty.

## Timing
- Reset values (asynchronous):
  - state = IDLE
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - rdata0 = 0, rdata1 = 0
  - conflict_cnt = 0
  - stall_mem is driven by the inputs alone (IDLE).
- Single access with zero-wait memory (ack in the first L0 cycle):
  - Cycle sequence: IDLE (stall) → L0 (stall, req) → DONE (no stall).
  - Cost: 2 stall cycles.
- Dual access with zero-wait memory:
  - Cycle sequence: IDLE → L0 → L1 → DONE.
  - Cost: 3 stall cycles.
- Each wait cycle (req = 1, ack = 0) adds one stall cycle. mem_addr, mem_wdata and mem_we stay stable while req = 1 and ack = 0.
- mem_ack sampled outside L0 or L1 is ignored.
- Reset asserted mid-transaction: mem_req drops immediately, the state returns to IDLE, and the partial pair is abandoned. The memory must tolerate the dropped request.
- When the counter is saturated and another conflict occurs, the counter holds at its maximum value.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum: IDLE, L0, L1, DONE (2 bits)
  - the lane index constants: LANE0 = 0, LANE1 = 1
- Sub-module sat_counter (parameter W): an increment-enable counter that holds at all-ones. The arbiter instantiates it once for conflict_cnt.
- All remaining logic is a single FSM plus the output mux, in dmem_arbiter.

## Test plan
- Lane 0 load only: addr0 = 0x10, ack in the first L0 cycle, mem_rdata = 0xDEADBEEF → stall_mem is high for 2 cycles and rdata0 = 0xDEADBEEF.
- Pair with lane 0 store 0x55 to 0x20 and lane 1 load from 0x20 → the memory sees the write, then the read. rdata1 = 0x55, stall is 3 cycles and conflict_cnt = 1.
- Lane 1 store only, with 2 wait cycles → mem_addr and mem_wdata are stable for 3 cycles of req, stall_mem lasts 4 cycles, and rdata0/rdata1 are unchanged.
- No memory access in either lane → stall_mem stays 0 and mem_req stays 0 for 10 consecutive pairs.
- Reset asserted while in L1 with ack low → mem_req falls with no clock edge, state = IDLE, and all outputs are at their reset values.
- Force conflict_cnt to 0xFFFE via 65534 conflicting pairs, then run 2 more → the counter reads 0xFFFF and holds there.
